// File: rtl/vid_cfg_pkg.sv
// Shared definitions for the configurable video pipeline.
// Holds the per-stage op codes and the fixed-point grayscale weights.
package vid_cfg_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_PASS     = 3'd0,
        OP_GRAY     = 3'd1,
        OP_INVERT   = 3'd2,
        OP_CONTRAST = 3'd3,
        OP_THRESH   = 3'd4
    } op_e;

    // Luma weights, scaled by 256 (sum = 256).
    localparam int GRAY_KR = 77;
    localparam int GRAY_KG = 150;
    localparam int GRAY_KB = 29;

endpackage

// File: rtl/vid_cfg_stage.sv
// One pipeline stage: applies op field IDX of the beat, then a handshake register.
// Ports: clk_i/rst_i, upstream valid_i/data_i, downstream ready_i, valid_o/data_o.
module vid_cfg_stage
    import vid_cfg_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int N_STAGES = 4,
    parameter int IDX      = 0
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                valid_i,
    input  logic [4*DATA_W+3*N_STAGES+2:0]      data_i,
    input  logic                                ready_i,
    output logic                                valid_o,
    output logic [4*DATA_W+3*N_STAGES+2:0]      data_o
);

    typedef struct packed {
        logic [DATA_W-1:0] r;
        logic [DATA_W-1:0] g;
        logic [DATA_W-1:0] b;
        logic              hsync;
        logic              vsync;
        logic              vde;
    } pixel_t;

    typedef struct packed {
        pixel_t                    pix;
        logic [OP_W*N_STAGES-1:0]  ops;
        logic [DATA_W-1:0]         thr;
    } beat_t;

    localparam logic [DATA_W+7:0] KR = (DATA_W+8)'(GRAY_KR);
    localparam logic [DATA_W+7:0] KG = (DATA_W+8)'(GRAY_KG);
    localparam logic [DATA_W+7:0] KB = (DATA_W+8)'(GRAY_KB);
    localparam logic [DATA_W+1:0] MID = (DATA_W+2)'(1) << (DATA_W-1);

    // 2x - mid, saturated; t is a DATA_W+2 bit two's complement value.
    function automatic logic [DATA_W-1:0] contrast(input logic [DATA_W-1:0] x);
        logic [DATA_W+1:0] t;
        t = {1'b0, x, 1'b0} - MID;
        if (t[DATA_W+1]) begin
            return '0;
        end else if (t[DATA_W]) begin
            return '1;
        end
        return t[DATA_W-1:0];
    endfunction

    beat_t             up;
    beat_t             data_d;
    beat_t             data_q;
    logic              valid_q;
    logic              ready_up;
    logic [OP_W-1:0]   op;
    logic [DATA_W+7:0] ysum;
    logic [DATA_W-1:0] y;

    assign up       = data_i;
    assign op       = up.ops[OP_W*IDX +: OP_W];
    assign ready_up = ~valid_q | ready_i;

    assign ysum = KR * {8'd0, up.pix.r}
                + KG * {8'd0, up.pix.g}
                + KB * {8'd0, up.pix.b};
    assign y    = ysum[DATA_W+7:8];

    always_comb begin
        data_d = up;
        case (op)
            OP_GRAY: begin
                data_d.pix.r = y;
                data_d.pix.g = y;
                data_d.pix.b = y;
            end
            OP_INVERT: begin
                data_d.pix.r = ~up.pix.r;
                data_d.pix.g = ~up.pix.g;
                data_d.pix.b = ~up.pix.b;
            end
            OP_CONTRAST: begin
                data_d.pix.r = contrast(up.pix.r);
                data_d.pix.g = contrast(up.pix.g);
                data_d.pix.b = contrast(up.pix.b);
            end
            OP_THRESH: begin
                data_d.pix.r = (up.pix.r >= up.thr) ? '1 : '0;
                data_d.pix.g = (up.pix.g >= up.thr) ? '1 : '0;
                data_d.pix.b = (up.pix.b >= up.thr) ? '1 : '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            if (ready_up) begin
                valid_q <= valid_i;
            end
            if (valid_i & ready_up) begin
                data_q <= data_d;
            end
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/vid_pipeline_cfg.sv
// RGB pixel pipeline of N_STAGES op stages; config latched at frame start.
// Ports: pixel/sync in with valid/ready, pixel/sync out with valid/ready, frame count, busy.
module vid_pipeline_cfg
    import vid_cfg_pkg::*;
#(
    parameter int N_STAGES = 4,
    parameter int DATA_W   = 8,
    parameter int CNT_W    = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [3*N_STAGES-1:0]    cfg_i,
    input  logic [DATA_W-1:0]        thr_i,
    input  logic [DATA_W-1:0]        r_i,
    input  logic [DATA_W-1:0]        g_i,
    input  logic [DATA_W-1:0]        b_i,
    input  logic                     hsync_i,
    input  logic                     vsync_i,
    input  logic                     vde_i,
    input  logic                     valid_i,
    output logic                     ready_o,
    output logic [DATA_W-1:0]        r_o,
    output logic [DATA_W-1:0]        g_o,
    output logic [DATA_W-1:0]        b_o,
    output logic                     hsync_o,
    output logic                     vsync_o,
    output logic                     vde_o,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic [CNT_W-1:0]         frame_cnt_o,
    output logic                     busy_o
);

    localparam int BW = 4*DATA_W + 3*N_STAGES + 3;

    typedef struct packed {
        logic [DATA_W-1:0] r;
        logic [DATA_W-1:0] g;
        logic [DATA_W-1:0] b;
        logic              hsync;
        logic              vsync;
        logic              vde;
    } pixel_t;

    typedef struct packed {
        pixel_t                    pix;
        logic [OP_W*N_STAGES-1:0]  ops;
        logic [DATA_W-1:0]         thr;
    } beat_t;

    logic [3*N_STAGES-1:0] cfg_q, cfg_d;
    logic [DATA_W-1:0]     thr_q, thr_d;
    logic                  vs_in_q;
    logic                  vs_out_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  in_acc;
    logic                  out_acc;
    logic                  sof;
    beat_t                 in_beat;
    beat_t                 out_beat;
    logic [N_STAGES-1:0]   vq;
    logic [BW-1:0]         dq [N_STAGES];
    logic [N_STAGES-1:0]   up_rdy;
    logic                  unused_tail;

    assign in_acc  = valid_i & ready_o;
    assign out_acc = valid_o & ready_i;
    assign sof     = in_acc & vsync_i & ~vs_in_q;

    // The SOF beat itself must already see the new config.
    assign cfg_d = sof ? cfg_i : cfg_q;
    assign thr_d = sof ? thr_i : thr_q;

    always_comb begin
        in_beat           = '0;
        in_beat.pix.r     = r_i;
        in_beat.pix.g     = g_i;
        in_beat.pix.b     = b_i;
        in_beat.pix.hsync = hsync_i;
        in_beat.pix.vsync = vsync_i;
        in_beat.pix.vde   = vde_i;
        in_beat.ops       = cfg_d;
        in_beat.thr       = thr_d;
    end

    // Stage k can accept when any stage at or after it has room,
    // or the sink is ready.
    always_comb begin
        up_rdy = '0;
        up_rdy[N_STAGES-1] = ~vq[N_STAGES-1] | ready_i;
        for (int k = N_STAGES-2; k >= 0; k--) begin
            up_rdy[k] = ~vq[k] | up_rdy[k+1];
        end
    end

    for (genvar k = 0; k < N_STAGES; k++) begin : g_stage
        logic          up_v;
        logic [BW-1:0] up_d;
        logic          dn_r;

        if (k == 0) begin : g_first
            assign up_v = valid_i;
            assign up_d = in_beat;
        end else begin : g_mid
            assign up_v = vq[k-1];
            assign up_d = dq[k-1];
        end

        if (k == N_STAGES-1) begin : g_last
            assign dn_r = ready_i;
        end else begin : g_inner
            assign dn_r = up_rdy[k+1];
        end

        vid_cfg_stage #(
            .DATA_W   (DATA_W),
            .N_STAGES (N_STAGES),
            .IDX      (k)
        ) u_stage (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .valid_i (up_v),
            .data_i  (up_d),
            .ready_i (dn_r),
            .valid_o (vq[k]),
            .data_o  (dq[k])
        );
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cfg_q    <= '0;
            thr_q    <= '0;
            vs_in_q  <= 1'b0;
            vs_out_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            cfg_q <= cfg_d;
            thr_q <= thr_d;
            if (in_acc) begin
                vs_in_q <= vsync_i;
            end
            if (out_acc) begin
                vs_out_q <= vsync_o;
                if (vsync_o & ~vs_out_q) begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end
        end
    end

    assign out_beat    = dq[N_STAGES-1];
    assign unused_tail = ^{out_beat.ops, out_beat.thr};

    assign ready_o     = up_rdy[0];
    assign valid_o     = vq[N_STAGES-1];
    assign r_o         = out_beat.pix.r;
    assign g_o         = out_beat.pix.g;
    assign b_o         = out_beat.pix.b;
    assign hsync_o     = out_beat.pix.hsync;
    assign vsync_o     = out_beat.pix.vsync;
    assign vde_o       = out_beat.pix.vde;
    assign frame_cnt_o = cnt_q;
    assign busy_o      = |vq;

endmodule

// File: tb/tb_vid_pipeline_cfg.sv
// Randomised and directed bench for vid_pipeline_cfg.
// Reference model works on whole frames/beats with integer arithmetic.
module tb_vid_pipeline_cfg;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int CW = 16;
    localparam int MAXV = (1 << W) - 1;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic [3*N-1:0] cfg_i;
    logic [W-1:0]  thr_i;
    logic [W-1:0]  r_i, g_i, b_i;
    logic          hsync_i, vsync_i, vde_i;
    logic          valid_i;
    logic          ready_o;
    logic [W-1:0]  r_o, g_o, b_o;
    logic          hsync_o, vsync_o, vde_o;
    logic          valid_o;
    logic          ready_i;
    logic [CW-1:0] frame_cnt_o;
    logic          busy_o;

    always #5 clk_i = ~clk_i;

    vid_pipeline_cfg #(
        .N_STAGES (N),
        .DATA_W   (W),
        .CNT_W    (CW)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .cfg_i       (cfg_i),
        .thr_i       (thr_i),
        .r_i         (r_i),
        .g_i         (g_i),
        .b_i         (b_i),
        .hsync_i     (hsync_i),
        .vsync_i     (vsync_i),
        .vde_i       (vde_i),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .r_o         (r_o),
        .g_o         (g_o),
        .b_o         (b_o),
        .hsync_o     (hsync_o),
        .vsync_o     (vsync_o),
        .vde_o       (vde_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .frame_cnt_o (frame_cnt_o),
        .busy_o      (busy_o)
    );

    typedef struct {
        int     r;
        int     g;
        int     b;
        bit     hs;
        bit     vs;
        bit     de;
        longint t;
    } exp_t;

    exp_t        q[$];
    int          n_chk = 0;
    int          n_pass = 0;
    int          m_cnt, m_cfg, m_thr;
    bit          m_vs_in, m_vs_out;
    longint      cyc = 0;
    bit          bp = 0;
    bit          lat_chk = 0;
    bit          in_acc;
    bit          held = 0;
    logic [26:0] snap;
    logic [23:0] last_out;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic int ctr(input int x);
        int t;
        t = 2*x - (1 << (W-1));
        if (t < 0) return 0;
        if (t > MAXV) return MAXV;
        return t;
    endfunction

    function automatic void apply_op(input int op, input int thr,
                                     inout int r, inout int g, inout int b);
        int y;
        case (op)
            1: begin
                y = (77*r + 150*g + 29*b) / 256;
                r = y; g = y; b = y;
            end
            2: begin r = MAXV - r; g = MAXV - g; b = MAXV - b; end
            3: begin r = ctr(r); g = ctr(g); b = ctr(b); end
            4: begin
                r = (r >= thr) ? MAXV : 0;
                g = (g >= thr) ? MAXV : 0;
                b = (b >= thr) ? MAXV : 0;
            end
            default: ;
        endcase
    endfunction

    task automatic cycle();
        exp_t        e;
        int          ops, thr;
        logic [26:0] cur, ev;
        if (bp) ready_i = ($urandom_range(0, 99) >= 30);
        @(negedge clk_i);
        #1;
        in_acc = 0;
        cur = {r_o, g_o, b_o, hsync_o, vsync_o, vde_o};
        if (rst_i) begin
            q.delete();
            m_cnt = 0; m_cfg = 0; m_thr = 0;
            m_vs_in = 0; m_vs_out = 0;
            held = 0;
        end else begin
            chk("ready_o", ready_o, !(q.size() == N && !ready_i));
            chk("busy_o", busy_o, q.size() != 0);
            chk("frame_cnt", frame_cnt_o, m_cnt);
            if (held) begin
                chk("stall_valid", valid_o, 1);
                chk("stall_data", cur, snap);
            end
            if (valid_o && ready_i) begin
                if (q.size() == 0) begin
                    chk("spurious_out", 1, 0);
                end else begin
                    e  = q.pop_front();
                    ev = {8'(e.r), 8'(e.g), 8'(e.b), e.hs, e.vs, e.de};
                    chk("pixel", cur, ev);
                    if (lat_chk) chk("latency", cyc - e.t, N);
                end
                last_out = {r_o, g_o, b_o};
                if (vsync_o && !m_vs_out) m_cnt = (m_cnt + 1) % (1 << CW);
                m_vs_out = vsync_o;
            end
            held = valid_o && !ready_i;
            snap = cur;
            if (valid_i && ready_o) begin
                in_acc = 1;
                if (vsync_i && !m_vs_in) begin
                    m_cfg = int'(cfg_i);
                    m_thr = int'(thr_i);
                end
                ops = m_cfg;
                thr = m_thr;
                m_vs_in = vsync_i;
                e.r = r_i; e.g = g_i; e.b = b_i;
                e.hs = hsync_i; e.vs = vsync_i; e.de = vde_i;
                e.t = cyc;
                for (int k = 0; k < N; k++)
                    apply_op((ops >> (3*k)) & 7, thr, e.r, e.g, e.b);
                q.push_back(e);
            end
        end
        @(posedge clk_i);
        cyc++;
        #1;
    endtask

    task automatic send(input int r, input int g, input int b,
                        input bit hs, input bit vs, input bit de);
        r_i = W'(r); g_i = W'(g); b_i = W'(b);
        hsync_i = hs; vsync_i = vs; vde_i = de;
        valid_i = 1'b1;
        in_acc = 0;
        for (int k = 0; k < 200; k++) begin
            cycle();
            if (in_acc) break;
        end
        if (!in_acc) chk("send_timeout", 0, 1);
        valid_i = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        valid_i = 1'b0;
        while ((q.size() != 0 || busy_o) && k < 500) begin
            cycle();
            k++;
        end
        chk("drain_left", q.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_i = 1'b1; cfg_i = '0; thr_i = '0;
        r_i = '0; g_i = '0; b_i = '0;
        hsync_i = 0; vsync_i = 0; vde_i = 0;
        valid_i = 0; ready_i = 1'b1;
        cycle();
        cycle();
        rst_i = 1'b0;
        chk("rst_valid", valid_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_ready", ready_o, 1);
        chk("rst_fcnt", frame_cnt_o, 0);
        chk("rst_pix", {r_o, g_o, b_o}, 0);

        // passthrough, back to back, fixed latency
        lat_chk = 1;
        for (int i = 0; i < 100; i++)
            send('h12, 'h34, 'h56, (i % 10) == 0, i < 2, 1'b1);
        drain();
        lat_chk = 0;
        chk("pass_fcnt", frame_cnt_o, 1);
        chk("pass_pix", last_out, 24'h123456);

        // gray -> invert -> contrast -> pass
        cfg_i = {3'd0, 3'd3, 3'd2, 3'd1};
        send(200, 100, 50, 0, 1, 1);
        drain();
        chk("ops_chain", last_out, {8'd134, 8'd134, 8'd134});
        send(10, 20, 30, 0, 0, 1);

        // mid-frame config change waits for next SOF
        cfg_i = 12'h001;
        send(200, 100, 50, 0, 1, 1);
        cfg_i = 12'h002;
        send(200, 100, 50, 0, 0, 1);
        drain();
        chk("mid_gray", last_out, {8'd124, 8'd124, 8'd124});
        send(200, 100, 50, 0, 1, 1);
        drain();
        chk("sof_inv", last_out, {8'd55, 8'd155, 8'd205});
        send(200, 100, 50, 0, 0, 1);
        drain();
        chk("post_inv", last_out, {8'd55, 8'd155, 8'd205});

        // threshold edges; thr change mid-frame ignored
        cfg_i = 12'h004;
        thr_i = 8'd128;
        send(127, 128, 255, 0, 1, 1);
        drain();
        chk("thr_edge", last_out, {8'd0, 8'd255, 8'd255});
        thr_i = 8'd10;
        send(20, 200, 0, 0, 0, 1);
        drain();
        chk("thr_held", last_out, {8'd0, 8'd255, 8'd0});

        // contrast clamps
        cfg_i = 12'h003;
        send(0, 255, 128, 0, 1, 1);
        drain();
        chk("ctr_edge", last_out, {8'd0, 8'd255, 8'd128});
        send(64, 192, 1, 0, 0, 1);
        drain();
        chk("ctr_mid", last_out, {8'd0, 8'd255, 8'd0});

        // random traffic with 30% backpressure
        bp = 1;
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                valid_i = 1'b0;
                cycle();
            end
            cfg_i = 12'($urandom);
            thr_i = 8'($urandom);
            send($urandom_range(0, 255), $urandom_range(0, 255),
                 $urandom_range(0, 255), $urandom_range(0, 1),
                 (i % 50) < 3, $urandom_range(0, 1));
        end
        bp = 0;
        ready_i = 1'b1;
        drain();

        // reset with all stages full
        ready_i = 1'b0;
        cfg_i = 12'h002;
        for (int i = 0; i < N; i++) send(200, 100, 50, 0, 1, 1);
        chk("full_ready", ready_o, 0);
        rst_i = 1'b1;
        cycle();
        rst_i = 1'b0;
        chk("mrst_valid", valid_o, 0);
        chk("mrst_busy", busy_o, 0);
        chk("mrst_fcnt", frame_cnt_o, 0);
        chk("mrst_ready", ready_o, 1);
        ready_i = 1'b1;
        cfg_i = 12'h001;
        send(200, 100, 50, 0, 1, 1);
        drain();
        chk("mrst_sof", last_out, {8'd124, 8'd124, 8'd124});
        chk("mrst_fcnt1", frame_cnt_o, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/vid_pipeline_cfg.md
Name: vid_pipeline_cfg

Overview:
Parametrised successor of the fixed four-filter video pipeline. Processes an RGB pixel stream through N_STAGES registered stages with valid/ready handshake. Each stage applies a runtime-selectable operation from a shared op set. Configuration is sampled only at frame start and travels with each beat, so every pixel of a frame sees one consistent configuration. Sits between the video input formatter and the video output encoder.

Parameters:
N_STAGES, 4, number of processing and register stages (>=1)
DATA_W, 8, bits per colour channel (>=4)
CNT_W, 16, width of the output frame counter

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
cfg_i  in  3*N_STAGES  op code per stage; field k = bits [3k+2:3k]
thr_i  in  DATA_W  threshold for OP_THRESH
r_i, g_i, b_i  in  DATA_W each  input pixel
hsync_i, vsync_i, vde_i  in  1 each  input sync/enable, carried with the pixel
valid_i  in  1  input beat valid
ready_o  out  1  input beat accepted when valid_i & ready_o
r_o, g_o, b_o  out  DATA_W each  output pixel
hsync_o, vsync_o, vde_o  out  1 each  delayed sync/enable
valid_o  out  1  output beat valid
ready_i  in  1  downstream ready
frame_cnt_o  out  CNT_W  count of frames started at the output
busy_o  out  1  any stage holds a valid beat

Behaviour:
- Reset (rst_i high at a clk_i edge): all stage valid = 0, all data/sync = 0, frame_cnt_o = 0, cfg_q = all OP_PASS, thr_q = 0, vs_in_q = 0, vs_out_q = 0. Result: valid_o = 0, busy_o = 0, ready_o = 1 on the next cycle. Reset mid-frame discards all in-flight beats.
- Stage register: ready_up = ~valid_q | ready_dn. Load when valid_up & ready_up. Clear valid_q when ready_dn & ~valid_up. Full throughput: one beat per cycle, no bubbles. Latency is N_STAGES cycles when there is no backpressure. ready_o is combinational from the stage-0 state and the downstream chain.
- Frame start (SOF): accepted input beat with vsync_i = 1 while vs_in_q = 0. vs_in_q updates only on accepted beats.
  - On SOF: cfg_q <= cfg_i and thr_q <= thr_i; the SOF beat itself uses cfg_i/thr_i.
  - Other beats use cfg_q/thr_q.
  - The selected op vector and threshold are stored with the beat and shift down the pipeline with it. Stage k applies op field k of the beat it is processing.
  - Changes to cfg_i mid-frame have no effect until the next SOF.
- Ops, applied per stage to the registered input:
  - OP_PASS = 0: unchanged.
  - OP_GRAY = 1: y = (77r + 150g + 29b) >> 8, computed at DATA_W+8 bits, truncated to DATA_W. r = g = b = y.
  - OP_INVERT = 2: x' = 2^DATA_W - 1 - x per channel.
  - OP_CONTRAST = 3: x' = clamp(2x - 2^(DATA_W-1), 0, 2^DATA_W - 1), signed intermediate of DATA_W+2 bits.
  - OP_THRESH = 4: x' = (x >= thr) ? all-ones : 0, per channel.
  - Codes 5-7: treated as OP_PASS.
- hsync, vsync and vde pass through unmodified with their pixel.
- frame_cnt_o increments by 1 on an accepted output beat (valid_o & ready_i) with vsync_o = 1 while vs_out_q = 0. It wraps modulo 2^CNT_W. vs_out_q updates only on accepted output beats.
- Stalled output (valid_o & ~ready_i): all outputs are held stable until accepted.

Decomposition:
- Package vid_cfg_pkg holds:
  - op_e (3-bit enum with the codes above)
  - pixel_t struct {r, g, b, hsync, vsync, vde}, parameterised by DATA_W via localparam/typedef in the user module
  - GRAY_KR = 77, GRAY_KG = 150, GRAY_KB = 29
- Sub-module vid_cfg_stage: one op unit plus one handshake register. Its beat payload is {pixel, op vector, thr}.
- Top: generate loop of N_STAGES vid_cfg_stage instances, plus the SOF/config capture and the output frame counter.

Test Plan:
- Passthrough. cfg_i = 0, ready_i = 1, 100 beats, r/g/b = 8'h12/34/56 → identical outputs with 4-cycle latency, valid_o continuous, frame_cnt_o = 1 after the first vsync beat.
- Per-stage ops. DATA_W = 8, cfg = {PASS, CONTRAST, INVERT, GRAY}, input (200, 100, 50) → gray = (15400 + 15000 + 1450) >> 8 = 124; inverted = 131; contrast = 2*131 - 128 = 134. Output (134, 134, 134).
- Mid-frame config change. Frame starts with GRAY on stage 0; switch cfg_i to INVERT mid-frame → all pixels of that frame are gray. The first pixel of the next frame (SOF) and later pixels are inverted.
- Backpressure. Random ready_i at 30% low for 1000 beats → no beat lost or duplicated, order preserved, outputs stable while stalled, ready_o = 0 only when all stages are full and ready_i = 0.
- Threshold and clamp edges. thr = 128, inputs 127/128/255/0 → 0/255/255/0. Contrast on 0 → 0, on 255 → 255 (clamped from 382).
- Reset mid-frame. Assert rst_i with 4 stages full → next cycle valid_o = 0, busy_o = 0, frame_cnt_o = 0, ready_o = 1. The next vsync beat is treated as SOF.
